ssd_scan_decoder: RTL

//   Decoder end of the seven-segment display interface: snoops a multiplexed,

---
 rtl/ssd_pkg.sv | 23 ++
 rtl/ssd_scan_decoder_if.sv | 11 +
 rtl/ssd_pattern_decode.sv | 25 ++
 rtl/ssd_scan_decoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the seven-segment scan decoder.
// Segment patterns are active-low, bit0=a .. bit6=g.
package ssd_pkg;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {SETTLE, HELD} state_e;

  // Unused upper anode bits must be padded with ones by the caller.
  function automatic logic ANODE_ONEHOT(input logic [7:0] an_n);
    int zeros;
    zeros = 0;
    for (int k = 0; k < 8; k++)
      if (!an_n[k]) zeros++;
    return (zeros == 1);
  endfunction

endpackage

// File: rtl/ssd_scan_decoder_if.sv
// Multiplexed seven-segment display bus: segments and anodes, both active-low.
// The encoder drives it (master); the scan decoder snoops it (slave).
interface ssd_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]            seg_n;
  logic [NUM_DIGITS-1:0] an_n;

  modport master (output seg_n, output an_n);
  modport slave  (input  seg_n, input  an_n);
endinterface

// File: rtl/ssd_pattern_decode.sv
// Combinational segment-pattern classifier: hex nibble, legal (hex or blank), blank.
// Kept standalone so a display self-checker can reuse it.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_n_i,
  output logic [3:0] nibble_o,
  output logic       legal_o,
  output logic       blank_o
);

  always_comb begin
    nibble_o = '0;
    legal_o  = 1'b0;
    blank_o  = (seg_n_i == SEG_BLANK);
    for (int k = 0; k < 16; k++) begin
      if (seg_n_i == SEG_HEX[k]) begin
        nibble_o = 4'(k);
        legal_o  = 1'b1;
      end
    end
    if (blank_o) legal_o = 1'b1;
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Snoops a multiplexed active-low segment/anode bus and rebuilds the digit shown
// at each position once the bus has been stable for STABLE_CYCLES synced samples.
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  ssd_scan_decoder_if.slave       bus,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    frame_done,
  output logic                    err_illegal,
  output logic                    err_multi
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int SW = NUM_DIGITS + 7;

  // Sync flops reset to the idle bus (all off) so an idle panel never looks like a change.
  logic [SW-1:0] sync1_q, s_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '1;
      s_q     <= '1;
    end else begin
      sync1_q <= {bus.an_n, bus.seg_n};
      s_q     <= sync1_q;
    end
  end

  logic [NUM_DIGITS-1:0] an_s;
  logic [6:0]            seg_s;
  assign an_s  = s_q[SW-1:7];
  assign seg_s = s_q[6:0];

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          chg, eval_en;

  // s changes on this edge; cnt counts cycles s has held its current value.
  assign chg = (sync1_q != s_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SETTLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (chg) begin
      state_d = SETTLE;
      cnt_d   = CW'(1);
    end else if (state_q == SETTLE) begin
      if (cnt_q == CW'(STABLE_CYCLES)) state_d = HELD;
      else                             cnt_d   = cnt_q + CW'(1);
    end
  end

  always_comb begin
    eval_en = (state_q == SETTLE) && (cnt_q == CW'(STABLE_CYCLES));
  end

  logic [3:0] nib;
  logic       legal, blank;

  ssd_pattern_decode u_dec (
    .seg_n_i  (seg_s),
    .nibble_o (nib),
    .legal_o  (legal),
    .blank_o  (blank)
  );

  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, blank_q, blank_d, seen_q, seen_d, cap_bit;
  logic                    update_q, update_d, frame_q, frame_d;
  logic [2:0]              idx_q, idx_d;
  logic                    ill_q, ill_d, multi_q, multi_d, ill_new, multi_new;
  logic [7:0]              an_pad;

  always_comb begin
    digits_d  = digits_q;
    valid_d   = valid_q;
    blank_d   = blank_q;
    update_d  = 1'b0;
    idx_d     = idx_q;
    cap_bit   = '0;
    ill_new   = 1'b0;
    multi_new = 1'b0;
    an_pad    = '1;
    an_pad[NUM_DIGITS-1:0] = an_s;

    if (eval_en && !(&an_s)) begin
      if (!ANODE_ONEHOT(an_pad)) begin
        multi_new = 1'b1;
      end else begin
        update_d = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (!an_s[k]) begin
            idx_d      = 3'(k);
            cap_bit[k] = 1'b1;
            valid_d[k] = legal;
            blank_d[k] = blank;
            if (legal && !blank) digits_d[4*k +: 4] = nib;
            if (!legal)          ill_new = 1'b1;
          end
        end
      end
    end

    // A full mask is reported and cleared together; a capture here starts the next frame.
    frame_d = &seen_q;
    seen_d  = ((&seen_q) ? '0 : seen_q) | cap_bit;
    ill_d   = (ill_q   & ~err_clr) | ill_new;
    multi_d = (multi_q & ~err_clr) | multi_new;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits_q <= '0;
      valid_q  <= '0;
      blank_q  <= '0;
      update_q <= 1'b0;
      idx_q    <= '0;
      frame_q  <= 1'b0;
      seen_q   <= '0;
      ill_q    <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      blank_q  <= blank_d;
      update_q <= update_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      seen_q   <= seen_d;
      ill_q    <= ill_d;
      multi_q  <= multi_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign update      = update_q;
  assign update_idx  = idx_q;
  assign frame_done  = frame_q;
  assign err_illegal = ill_q;
  assign err_multi   = multi_q;

endmodule
